// File: rtl/param_up_down_counter.sv
// param_up_down_counter: parametrised up/down event counter with
// clear, load, wrap/saturate mode and an optional prescaler.
//
// Macro: UDC_PRESCALE_EN adds a divide-by-PRESCALE step prescaler.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-high reset
//   on       - count enable
//   up_down  - 1 = count up, 0 = count down
//   clear    - synchronous clear to 0 (highest priority)
//   load     - synchronous load of load_val (clamped to MODULUS-1)
//   load_val - value for load
//   sat      - 1 = saturate at the range limits, 0 = wrap
//   out      - registered count, always within 0..MODULUS-1
//   tc       - combinational terminal count in the current direction
//   wrap     - registered one-cycle pulse after a wrap event
module param_up_down_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             on,
   input  logic             up_down,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic             at_max;
   logic             at_zero;
   logic             step;
   logic [WIDTH-1:0] load_clamped;

   assign at_max  = (out == MAX);
   assign at_zero = (out == '0);

   // Out-of-range loads are only possible when MODULUS < 2**WIDTH.
   assign load_clamped = (load_val > MAX) ? MAX : load_val;

`ifdef UDC_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre <= '0;
      end else if (clear || load) begin
         pre <= '0;
      end else if (on) begin
         pre <= (pre == PMAX) ? '0 : pre + 1'b1;
      end
   end

   // The count only moves on the last prescaler phase.
   assign step = (pre == PMAX);
`else
   // Without the prescaler every enabled cycle is a step; a legal
   // PRESCALE (>= 1) makes this constant 1.
   assign step = (PRESCALE >= 1);
`endif

   assign tc = on & step &
               ((up_down & at_max) | (~up_down & at_zero));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clear) begin
            out <= '0;
         end else if (load) begin
            out <= load_clamped;
         end else if (on && step) begin
            // Limits are tested before stepping so out never
            // leaves 0..MAX, even transiently.
            if (up_down) begin
               if (!at_max) begin
                  out <= out + 1'b1;
               end else if (!sat) begin
                  out  <= '0;
                  wrap <= 1'b1;
               end
            end else begin
               if (!at_zero) begin
                  out <= out - 1'b1;
               end else if (!sat) begin
                  out  <= MAX;
                  wrap <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_param_up_down_counter.sv
// tb_param_up_down_counter: random and directed checks of two
// counter instances (MODULUS 16 and 10) against a behavioural model.
module tb_param_up_down_counter;

`ifdef UDC_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       on;
   logic       up_down;
   logic       clear;
   logic       load;
   logic [3:0] load_val;
   logic       sat;
   logic [3:0] out0, out1;
   logic       tc0, tc1, wrap0, wrap1;

   int n_cmp  = 0;
   int n_fail = 0;

   int m_o [2];
   int m_w [2];
   int m_pre;
   int mx [2] = '{15, 9};

   always #5 clk = ~clk;

   param_up_down_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(4)) u0 (
      .clk(clk), .reset(reset), .on(on), .up_down(up_down),
      .clear(clear), .load(load), .load_val(load_val), .sat(sat),
      .out(out0), .tc(tc0), .wrap(wrap0)
   );

   param_up_down_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u1 (
      .clk(clk), .reset(reset), .on(on), .up_down(up_down),
      .clear(clear), .load(load), .load_val(load_val), .sat(sat),
      .out(out1), .tc(tc1), .wrap(wrap1)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic int exp_tc(input int i);
      if (!on || m_pre != PS - 1) return 0;
      if (up_down) return (m_o[i] == mx[i]) ? 1 : 0;
      return (m_o[i] == 0) ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_o[i] = 0;
         m_w[i] = 0;
      end
      m_pre = 0;
   endtask

   // One rising edge of the reference behaviour.
   task automatic model_edge();
      bit stepnow;
      stepnow = (m_pre == PS - 1);
      for (int i = 0; i < 2; i++) begin
         m_w[i] = 0;
         if (clear) begin
            m_o[i] = 0;
         end else if (load) begin
            m_o[i] = (int'(load_val) > mx[i]) ? mx[i] : int'(load_val);
         end else if (on && stepnow) begin
            if (up_down) begin
               if (m_o[i] < mx[i]) m_o[i] = m_o[i] + 1;
               else if (!sat) begin
                  m_o[i] = 0;
                  m_w[i] = 1;
               end
            end else begin
               if (m_o[i] > 0) m_o[i] = m_o[i] - 1;
               else if (!sat) begin
                  m_o[i] = mx[i];
                  m_w[i] = 1;
               end
            end
         end
      end
      if (clear || load) m_pre = 0;
      else if (on) m_pre = (m_pre == PS - 1) ? 0 : m_pre + 1;
   endtask

   task automatic check_all();
      chk("out0", int'(out0), m_o[0]);
      chk("wrap0", int'(wrap0), m_w[0]);
      chk("tc0", int'(tc0), exp_tc(0));
      chk("out1", int'(out1), m_o[1]);
      chk("wrap1", int'(wrap1), m_w[1]);
      chk("tc1", int'(tc1), exp_tc(1));
   endtask

   // Called at a falling edge: drive, clock, then check at next fall.
   task automatic cyc(input bit on_i, input bit ud_i, input bit clr_i,
                      input bit ld_i, input bit sat_i,
                      input logic [3:0] lv_i);
      on       = on_i;
      up_down  = ud_i;
      clear    = clr_i;
      load     = ld_i;
      sat      = sat_i;
      load_val = lv_i;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Reset pulse entirely inside the low clock phase.
   task automatic async_rst();
      #2 reset = 1'b1;
      #1;
      chk("rst_out0", int'(out0), 0);
      chk("rst_wrap0", int'(wrap0), 0);
      chk("rst_out1", int'(out1), 0);
      chk("rst_wrap1", int'(wrap1), 0);
      model_reset();
      #1 reset = 1'b0;
      check_all();
   endtask

   initial begin
      bit dir;
      reset    = 1'b1;
      on       = 1'b0;
      up_down  = 1'b1;
      clear    = 1'b0;
      load     = 1'b0;
      load_val = '0;
      sat      = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_all();
      chk("reset_out0", int'(out0), 0);
      chk("reset_wrap0", int'(wrap0), 0);

`ifndef UDC_PRESCALE_EN
      for (int k = 1; k <= 15; k++) cyc(1, 1, 0, 0, 0, 4'd0);
      chk("up15_out0", int'(out0), 15);
      chk("up15_tc0", int'(tc0), 1);
      cyc(1, 1, 0, 0, 0, 4'd0);
      chk("wrapup_out0", int'(out0), 0);
      chk("wrapup_wrap0", int'(wrap0), 1);
      cyc(1, 1, 0, 0, 0, 4'd0);
      chk("after_wrap_out0", int'(out0), 1);
      chk("after_wrap_wrap0", int'(wrap0), 0);

      cyc(0, 1, 1, 0, 0, 4'd0);
      cyc(1, 0, 0, 0, 0, 4'd0);
      chk("down_out1", int'(out1), 9);
      chk("down_wrap1", int'(wrap1), 1);
      chk("down_out0", int'(out0), 15);
      cyc(1, 0, 0, 0, 0, 4'd0);
      chk("down2_out1", int'(out1), 8);
      chk("down2_wrap1", int'(wrap1), 0);
      cyc(1, 0, 0, 1, 0, 4'd13);
      chk("clamp_out1", int'(out1), 9);
      chk("load13_out0", int'(out0), 13);

      cyc(0, 1, 0, 1, 1, 4'd14);
      for (int k = 0; k < 4; k++) begin
         cyc(1, 1, 0, 0, 1, 4'd0);
         chk("sat_out0", int'(out0), 15);
         chk("sat_wrap0", int'(wrap0), 0);
      end
      cyc(1, 0, 0, 0, 1, 4'd0);
      chk("sat_down_out0", int'(out0), 14);

      cyc(0, 1, 0, 1, 0, 4'd7);
      cyc(1, 1, 1, 1, 0, 4'd3);
      chk("clr_ld_out0", int'(out0), 0);
      cyc(1, 1, 0, 1, 0, 4'd5);
      chk("ld_on_out0", int'(out0), 5);

      cyc(0, 1, 0, 1, 0, 4'd11);
      chk("ld11_out0", int'(out0), 11);
      on = 1'b1;
      async_rst();
      cyc(1, 1, 0, 0, 0, 4'd0);
      chk("resume_out0", int'(out0), 1);
`else
      cyc(0, 1, 1, 0, 0, 4'd0);
      for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 4'd0);
      chk("pre3_out0", int'(out0), 0);
      cyc(1, 1, 0, 0, 0, 4'd0);
      chk("pre4_out0", int'(out0), 1);
      cyc(0, 1, 0, 0, 0, 4'd0);
      cyc(0, 1, 0, 0, 0, 4'd0);
      for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 4'd0);
      chk("gap_hold_out0", int'(out0), 1);
      cyc(1, 1, 0, 0, 0, 4'd0);
      chk("gap_step_out0", int'(out0), 2);
`endif

      dir = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_rst();
         end else begin
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            cyc($urandom_range(0, 7) != 0, dir,
                $urandom_range(0, 31) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0,
                4'($urandom_range(0, 15)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
